// File: rtl/isa_read_server.sv
// Instruction-fetch DDR responder: turns one cache fetch request into a
// single DDR burst read and streams each beat back with a running count.
module isa_read_server #(
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int DDR_DATA_WIDTH = 64,
    parameter int ISA_WIDTH      = 30,
    parameter int MAX_BURST      = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ISA_read_req,
    input  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    input  logic [9:0]                isa_read_len,
    output logic [ISA_WIDTH-1:0]      instruction_to_cache,
    output logic                      rd_burst_data_valid,
    output logic [9:0]                rd_cnt_isa,
    output logic                      isa_rd_err,
    output logic                      rd_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
    output logic [9:0]                rd_burst_len,
    input  logic                      rd_burst_data_valid_ddr,
    input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data_ddr,
    input  logic                      rd_burst_finish
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA,
        DONE
    } state_t;

    localparam logic [9:0] MAX_LEN = 10'(MAX_BURST);

    state_t     state;
    logic [9:0] len_q;
    logic [9:0] req_len;
    logic       take;
    logic [9:0] cnt_next;
    logic       unused_hi;

    assign req_len   = (isa_read_len > MAX_LEN) ? MAX_LEN : isa_read_len;
    assign take      = rd_burst_data_valid_ddr && (rd_cnt_isa < len_q);
    assign cnt_next  = rd_cnt_isa + {9'd0, take};
    assign unused_hi = ^rd_burst_data_ddr[DDR_DATA_WIDTH-1:ISA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            len_q                <= '0;
            instruction_to_cache <= '0;
            rd_burst_data_valid  <= 1'b0;
            rd_cnt_isa           <= '0;
            isa_rd_err           <= 1'b0;
            rd_burst_req         <= 1'b0;
            rd_burst_addr        <= '0;
            rd_burst_len         <= '0;
        end else begin
            rd_burst_data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ISA_read_req) begin
                        len_q      <= req_len;
                        isa_rd_err <= 1'b0;
                        if (req_len == 10'd0) begin
                            state <= DONE;
                        end else begin
                            rd_burst_addr <= ISA_read_addr;
                            rd_burst_len  <= req_len;
                            rd_burst_req  <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE, DATA: begin
                    if (take) begin
                        instruction_to_cache <= rd_burst_data_ddr[ISA_WIDTH-1:0];
                        rd_burst_data_valid  <= 1'b1;
                        rd_cnt_isa           <= cnt_next;
                    end
                    if (rd_burst_data_valid_ddr || rd_burst_finish) begin
                        rd_burst_req <= 1'b0;
                        state        <= DATA;
                    end
                    // A beat accepted together with finish still counts first
                    if (cnt_next == len_q) begin
                        rd_burst_req <= 1'b0;
                        state        <= DONE;
                    end else if (rd_burst_finish) begin
                        isa_rd_err   <= 1'b1;
                        rd_burst_req <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    rd_burst_req <= 1'b0;
                    if (!ISA_read_req) begin
                        rd_cnt_isa <= '0;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/isa_read_server.md
# isa_read_server

DDR-side responder for instruction fetch. It accepts a burst read request from the instruction cache (`ISA_read_req` / `ISA_read_addr` / `isa_read_len`) and runs one burst read on the DDR controller's read-burst port. It returns each beat's instruction word to the cache with `rd_burst_data_valid` and a running beat count `rd_cnt_isa`. It sits between the instruction cache and the DDR controller, beside the data-path DDR interface.

## Interface
- DDR_ADDR_WIDTH, 28, DDR byte-address width.
- DDR_DATA_WIDTH, 64, DDR read-beat width; must be ≥ ISA_WIDTH.
- ISA_WIDTH, 30, instruction width (OPCODE 4 + CAM addr 8 + operand-2 2 + MEM addr 16).
- MAX_BURST, 128, largest burst accepted; longer requests are clamped.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- ISA_read_req  in  1  cache fetch request, level, held until `rd_cnt_isa >= isa_read_len`.
- ISA_read_addr  in  DDR_ADDR_WIDTH  burst start address, used as given.
- isa_read_len  in  10  beats requested.
- instruction_to_cache  out  ISA_WIDTH  current instruction beat.
- rd_burst_data_valid  out  1  one-cycle pulse per delivered beat.
- rd_cnt_isa  out  10  number of beats delivered in the current fetch.
- isa_rd_err  out  1  sticky short-burst error for the current fetch.
- rd_burst_req  out  1  DDR burst read request.
- rd_burst_addr  out  DDR_ADDR_WIDTH  DDR burst address.
- rd_burst_len  out  10  DDR burst length in beats.
- rd_burst_data_valid_ddr  in  1  DDR beat valid.
- rd_burst_data_ddr  in  DDR_DATA_WIDTH  DDR beat data.
- rd_burst_finish  in  1  DDR burst complete, one-cycle pulse.

## Operation
- **States:** IDLE, ISSUE, DATA, DONE.
- **Reset** (`rst`=1 at a clk edge): state IDLE. All outputs 0: instruction_to_cache, rd_burst_data_valid, rd_cnt_isa, isa_rd_err, rd_burst_req, rd_burst_addr, rd_burst_len. Internal length register 0. Reset aborts any burst in progress; later DDR beats are ignored until a new request is accepted.
- **IDLE:**
  - On `ISA_read_req`=1, latch `len = min(isa_read_len, MAX_BURST)` and the address, and clear isa_rd_err.
  - If len=0, go to DONE and issue no DDR request.
  - Otherwise drive rd_burst_addr = latched address and rd_burst_len = len, and go to ISSUE.
- **ISSUE:**
  - rd_burst_req=1, held until the first `rd_burst_data_valid_ddr` or `rd_burst_finish`.
  - A beat arriving in ISA­SUE is handled exactly as in DATA; the state then moves to DATA.
- **DATA (per beat):** while `rd_burst_data_valid_ddr`=1 and rd_cnt_isa < len:
  - instruction_to_cache ← rd_burst_data_ddr[ISA_WIDTH-1:0]
  - rd_burst_data_valid ← 1
  - rd_cnt_isa ← rd_cnt_isa+1
  - Beats beyond len are dropped: no pulse, no count change.
- **DATA (exit):**
  - When rd_cnt_isa reaches len, go to DONE.
  - If `rd_burst_finish` arrives while the count (including any beat accepted that same cycle) is still below len, set isa_rd_err=1 and go to DONE.
- **DONE:**
  - rd_burst_req=0; rd_cnt_isa and instruction_to_cache hold.
  - When `ISA_read_req`=0 is sampled, rd_cnt_isa ← 0 and the state returns to IDLE.
  - A request still high in DONE is never re-served. The cache must drop and re-raise it, which guarantees a stale count never satisfies a new fetch.
- **Counter width:** rd_cnt_isa is 10 bits and never exceeds len ≤ MAX_BURST ≤ 1023, so it cannot wrap.

## Timing
- Request sampled in IDLE at edge N: rd_burst_req=1 from N+1.
- DDR beat valid at edge M: instruction_to_cache, rd_burst_data_valid and rd_cnt_isa update together at M+1. Latency is one cycle, registered.
- Back-to-back DDR beats give back-to-back valid pulses and one count step per cycle.
- rd_burst_data_valid is always a single-cycle pulse per beat and is 0 in IDLE and DONE.
- Last beat at edge M: state DONE from M+1. The cache then observes rd_cnt_isa = len and drops its request. Count clears one cycle after the drop is sampled.
- Simultaneous final beat and rd_burst_finish: the beat is counted; isa_rd_err is set only if the count is still below len.
- Minimum gap between fetches: one DONE→IDLE cycle plus one IDLE cycle.

## Test plan
- **Reset:** assert rst for 3 cycles mid-idle → every output 0 and state IDLE.
- **4-beat fetch:** req, addr=0x100, len=4; DDR returns data 0x11..0x14 on consecutive cycles then finish → rd_burst_addr=0x100, rd_burst_len=4; four pulses with count 1,2,3,4 and instruction 0x11..0x14; isa_rd_err=0; count returns to 0 one cycle after req drops.
- **Zero length:** len=0 → rd_burst_req never asserts; DONE with count 0; clean return to IDLE after req drops.
- **Clamp and overrun:** len=200 with MAX_BURST=128 → rd_burst_len=128; DDR sends 130 beats → exactly 128 pulses, count stops at 128.
- **Short burst:** len=8; DDR sends 5 beats then finish → count=5, isa_rd_err=1, state DONE; err clears at the next accepted request.
- **Reset mid-burst, then back-to-back fetches:** rst after 3 of 8 beats → all outputs 0 and remaining beats ignored; then two fetches (len=2, len=3) separated only by a 1-cycle req drop → counts end at 2 then 3, with no carry-over between fetches.
